dot_engine: RTL and testbench



---
 rtl/dot_engine.sv | 141 ++++++++++++++
 tb/tb_dot_engine.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_engine.sv
// dot_engine: walks two strided DRAM vectors, multiply-accumulates them and writes the
// accumulator back as little-endian bytes. Define DOT_ENGINE_SAT_EN for a saturating accumulator.
module dot_engine #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 8,
    parameter int ACC_W  = 24
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_a_base,
    input  logic [ADDR_W-1:0] i_b_base,
    input  logic [ADDR_W-1:0] i_a_stride,
    input  logic [ADDR_W-1:0] i_b_stride,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [ADDR_W-1:0] i_c_addr,
    input  logic [DATA_W-1:0] i_dram_in,
    output logic [ADDR_W-1:0] o_dram_addr,
    output logic              o_dram_read,
    output logic              o_dram_write,
    output logic [DATA_W-1:0] o_dram_out,
    output logic              o_busy,
    output logic              o_done,
    output logic [ACC_W-1:0]  o_result,
    output logic [2:0]        o_dbg_state
);
    // Handshake: i_start is looked at only in IDLE; o_busy is high in every other state,
    // o_done pulses for the single DONE cycle and the next start may arrive the cycle after.
    typedef enum logic [2:0] {
        IDLE = 3'd0, RD_A = 3'd1, RD_B = 3'd2, MAC = 3'd3, WR = 3'd4, DONE = 3'd5
    } state_t;

    localparam int WB    = (ACC_W + DATA_W - 1) / DATA_W;
    localparam int IDX_W = (WB > 1) ? $clog2(WB) : 1;
    localparam int PAD_W = WB * DATA_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WB - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   a_ptr, b_ptr, a_stride, b_stride, c_addr;
    logic [LEN_W-1:0]    cnt, cnt_dec;
    logic [ACC_W-1:0]    acc, acc_next;
    logic [DATA_W-1:0]   a_reg, wr_byte;
    logic [IDX_W-1:0]    wb_idx;
    logic [2*DATA_W-1:0] prod;
    logic [PAD_W-1:0]    acc_pad;

    assign prod    = {{DATA_W{1'b0}}, a_reg} * {{DATA_W{1'b0}}, i_dram_in};
    assign cnt_dec = cnt - LEN_W'(1);
    assign acc_pad = PAD_W'(acc);
    assign wr_byte = acc_pad[wb_idx*DATA_W +: DATA_W];

`ifdef DOT_ENGINE_SAT_EN
    // One extra bit catches the carry; a saturated value stays pinned since products are unsigned.
    logic [ACC_W:0] sum;
    assign sum      = {1'b0, acc} + (ACC_W+1)'(prod);
    assign acc_next = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_next = acc + ACC_W'(prod);
`endif

    assign o_busy      = (state_q != IDLE);
    assign o_done      = (state_q == DONE);
    assign o_dbg_state = state_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        o_dram_addr  = '0;
        o_dram_read  = 1'b0;
        o_dram_write = 1'b0;
        o_dram_out   = '0;
        case (state_q)
            IDLE: if (i_start) state_d = (i_len == '0) ? WR : RD_A;
            RD_A: begin
                o_dram_addr = a_ptr;
                o_dram_read = 1'b1;
                state_d     = RD_B;
            end
            RD_B: begin
                o_dram_addr = b_ptr;
                o_dram_read = 1'b1;
                state_d     = MAC;
            end
            MAC:  state_d = (cnt_dec != '0) ? RD_A : WR;
            WR: begin
                o_dram_addr  = c_addr + ADDR_W'(wb_idx);
                o_dram_write = 1'b1;
                o_dram_out   = wr_byte;
                if (wb_idx == LAST_IDX) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_ptr    <= '0;
            b_ptr    <= '0;
            a_stride <= '0;
            b_stride <= '0;
            c_addr   <= '0;
            cnt      <= '0;
            acc      <= '0;
            a_reg    <= '0;
            wb_idx   <= '0;
            o_result <= '0;
        end else begin
            case (state_q)
                IDLE: if (i_start) begin
                    a_ptr    <= i_a_base;
                    b_ptr    <= i_b_base;
                    a_stride <= i_a_stride;
                    b_stride <= i_b_stride;
                    c_addr   <= i_c_addr;
                    cnt      <= i_len;
                    acc      <= '0;
                    wb_idx   <= '0;
                end
                // Read data lags the strobe by a cycle: RD_B sees A's element, MAC sees B's.
                RD_B: a_reg <= i_dram_in;
                MAC: begin
                    acc   <= acc_next;
                    a_ptr <= a_ptr + a_stride;
                    b_ptr <= b_ptr + b_stride;
                    cnt   <= cnt_dec;
                end
                WR: begin
                    wb_idx <= wb_idx + IDX_W'(1);
                    if (wb_idx == LAST_IDX) o_result <= acc;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dot_engine.sv
// Bench for dot_engine: table of operations on a 24-bit and a 16-bit instance sharing one DRAM model.
module tb_dot_engine;
    typedef struct {
        logic        wide;
        logic [15:0] a_base, a_stride, b_base, b_stride, c_addr;
        logic [7:0]  len;
        logic [2:0][7:0] a_el, b_el;
        logic [23:0] exp_result;
        int          exp_lat;
    } vec_t;

`ifdef DOT_ENGINE_SAT_EN
    localparam logic [23:0] OVF2 = 24'h00FFFF;
    localparam logic [23:0] OVF3 = 24'h00FFFF;
`else
    localparam logic [23:0] OVF2 = 24'h00FC02;
    localparam logic [23:0] OVF3 = 24'h00FA03;
`endif

    logic        clk, rst, start0, start1, sel;
    logic [15:0] a_base, b_base, a_stride, b_stride, c_addr;
    logic [7:0]  len, dram_in;
    logic        rd0, wr0, busy0, done0, rd1, wr1, busy1, done1;
    logic [15:0] addr0, addr1, result1;
    logic [7:0]  out0, out1;
    logic [23:0] result0;
    logic [2:0]  state0, state1;
    logic [7:0]  mem [0:65535];

    logic [15:0] exp_rd_q[$];
    logic [23:0] exp_wr_q[$];
    int checks = 0, failures = 0, cyc = 0, done_cnt = 0, wr_seen = 0;
    int excl_err = 0, idle_err = 0;
    vec_t vecs[7];

    dot_engine #(.ACC_W(24)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start0),
        .i_a_base(a_base), .i_b_base(b_base), .i_a_stride(a_stride), .i_b_stride(b_stride),
        .i_len(len), .i_c_addr(c_addr), .i_dram_in(dram_in),
        .o_dram_addr(addr0), .o_dram_read(rd0), .o_dram_write(wr0), .o_dram_out(out0),
        .o_busy(busy0), .o_done(done0), .o_result(result0), .o_dbg_state(state0)
    );

    dot_engine #(.ACC_W(16)) dut16 (
        .i_clk(clk), .i_rst(rst), .i_start(start1),
        .i_a_base(a_base), .i_b_base(b_base), .i_a_stride(a_stride), .i_b_stride(b_stride),
        .i_len(len), .i_c_addr(c_addr), .i_dram_in(dram_in),
        .o_dram_addr(addr1), .o_dram_read(rd1), .o_dram_write(wr1), .o_dram_out(out1),
        .o_busy(busy1), .o_done(done1), .o_result(result1), .o_dbg_state(state1)
    );

    logic        rd, wr, done_sel, busy_sel;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data;
    logic [23:0] res_sel;
    assign rd       = rd0 | rd1;
    assign wr       = wr0 | wr1;
    assign bus_addr = (rd0 | wr0) ? addr0 : addr1;
    assign bus_data = wr0 ? out0 : out1;
    assign done_sel = sel ? done1 : done0;
    assign busy_sel = sel ? busy1 : busy0;
    assign res_sel  = sel ? {8'h00, result1} : result0;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // DRAM model: data returned the cycle after the read strobe
    always @(posedge clk) begin
        if (rd) dram_in <= mem[bus_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every bench cycle passes through here; it also acts as the bus monitor.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (rd0 && wr0) excl_err++;
        if (rd1 && wr1) excl_err++;
        if (!rd0 && !wr0 && addr0 != 16'h0) idle_err++;
        if (!rd1 && !wr1 && addr1 != 16'h0) idle_err++;
        if (!wr0 && out0 != 8'h0) idle_err++;
        if (!wr1 && out1 != 8'h0) idle_err++;
        if (rd) begin
            if (exp_rd_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL read_unexpected: got addr 0x%0h expected no read", bus_addr);
            end else chk("read_addr", 32'(bus_addr), 32'(exp_rd_q.pop_front()));
        end
        if (wr) begin
            wr_seen++;
            if (exp_wr_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL write_unexpected: got addr 0x%0h data 0x%0h expected no write", bus_addr, bus_data);
            end else chk("write_addr_data", 32'({bus_addr, bus_data}), 32'(exp_wr_q.pop_front()));
        end
        if (done_sel) done_cnt++;
    endtask

    function automatic vec_t mk(input logic wide, input logic [15:0] ab, as, bb, bs,
                                input logic [7:0] l, input logic [15:0] c,
                                input logic [23:0] ae, be, input logic [23:0] res, input int lat);
        vec_t v;
        v.wide = wide; v.a_base = ab; v.a_stride = as; v.b_base = bb; v.b_stride = bs;
        v.len = l; v.c_addr = c; v.a_el = ae; v.b_el = be; v.exp_result = res; v.exp_lat = lat;
        return v;
    endfunction

    // Load operands into DRAM and queue the reads and writes the engine must issue.
    task automatic expect_vec(input vec_t v);
        int wb;
        logic [15:0] aa, ba;
        wb = v.wide ? 2 : 3;
        for (int i = 0; i < int'(v.len); i++) begin
            aa = v.a_base + v.a_stride * 16'(i);
            ba = v.b_base + v.b_stride * 16'(i);
            mem[aa] = v.a_el[i];
            mem[ba] = v.b_el[i];
            exp_rd_q.push_back(aa);
            exp_rd_q.push_back(ba);
        end
        for (int k = 0; k < wb; k++)
            exp_wr_q.push_back({v.c_addr + 16'(k), v.exp_result[8*k +: 8]});
    endtask

    task automatic launch(input vec_t v, output int n);
        a_base = v.a_base; b_base = v.b_base; a_stride = v.a_stride; b_stride = v.b_stride;
        len = v.len; c_addr = v.c_addr; sel = v.wide;
        if (v.wide) start1 = 1'b1; else start0 = 1'b1;
        n = cyc;
        tick();
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input vec_t v, input int n);
        int lat;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (done_sel) begin
                lat = cyc - n;
                break;
            end
        end
        chk("done_latency", 32'(lat), 32'(v.exp_lat));
        chk("result", 32'(res_sel), 32'(v.exp_result));
        chk("reads_outstanding", 32'(exp_rd_q.size()), 32'd0);
        chk("writes_outstanding", 32'(exp_wr_q.size()), 32'd0);
        tick();
        chk("busy_after_done", 32'(busy_sel), 32'd0);
    endtask

    initial begin
        int n, rb, w0, d0;
        vec_t v;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; sel = 1'b0;
        a_base = '0; b_base = '0; a_stride = '0; b_stride = '0; len = '0; c_addr = '0;
        vecs[0] = mk(0, 16'h0100, 16'd1, 16'h0200, 16'd3, 8'd3, 16'h0300,
                     {8'd3, 8'd2, 8'd1}, {8'd6, 8'd5, 8'd4}, 24'h000020, 13);
        vecs[1] = mk(0, 16'h0100, 16'd1, 16'h0200, 16'd1, 8'd0, 16'h0400,
                     24'h0, 24'h0, 24'h000000, 4);
        vecs[2] = mk(0, 16'hFFFF, 16'd1, 16'h0500, 16'd1, 8'd2, 16'h0600,
                     {8'd0, 8'd3, 8'd2}, {8'd0, 8'd7, 8'd5}, 24'd31, 10);
        vecs[3] = mk(0, 16'h0700, 16'd2, 16'h0800, 16'd1, 8'd3, 16'hFFFE,
                     {8'h10, 8'h80, 8'hFF}, {8'h10, 8'h02, 8'hFF}, 24'h010001, 13);
        vecs[4] = mk(0, 16'h0900, 16'd1, 16'h0A00, 16'd1, 8'd1, 16'h0B00,
                     {8'd0, 8'd0, 8'd7}, {8'd0, 8'd0, 8'd9}, 24'd63, 7);
        vecs[5] = mk(1, 16'h1000, 16'd1, 16'h1100, 16'd1, 8'd2, 16'h1200,
                     24'hFFFFFF, 24'hFFFFFF, OVF2, 9);
        vecs[6] = mk(1, 16'h1000, 16'd1, 16'h1100, 16'd1, 8'd3, 16'h1300,
                     24'hFFFFFF, 24'hFFFFFF, OVF3, 12);

        repeat (3) tick();
        chk("reset_state", 32'(state0), 32'd0);
        chk("reset_busy", 32'(busy0), 32'd0);
        chk("reset_done", 32'(done0), 32'd0);
        chk("reset_strobes", 32'({rd0, wr0}), 32'd0);
        chk("reset_addr_out", 32'({addr0, out0}), 32'd0);
        chk("reset_result", 32'(result0), 32'd0);
        rst = 1'b0;
        tick();

        // table of operations, run back to back
        for (int i = 0; i < 7; i++) begin
            expect_vec(vecs[i]);
            launch(vecs[i], n);
            wait_done(vecs[i], n);
        end

        // reset during the second RD_B: no write-back, result cleared
        v = vecs[0];
        v.c_addr = 16'h0C00;
        expect_vec(v);
        exp_wr_q.delete();
        for (int k = 0; k < 2; k++) void'(exp_rd_q.pop_back());
        launch(v, n);
        rb = 0;
        for (int i = 0; i < 30 && rb < 2; i++) begin
            tick();
            if (state0 == 3'd2) rb++;
        end
        chk("reached_second_rd_b", 32'(rb), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_state", 32'(state0), 32'd0);
        chk("midrst_busy", 32'(busy0), 32'd0);
        chk("midrst_result", 32'(result0), 32'd0);
        w0 = wr_seen;
        repeat (20) tick();
        chk("midrst_no_writes", 32'(wr_seen - w0), 32'd0);
        chk("midrst_reads_left", 32'(exp_rd_q.size()), 32'd0);

        // start pulse while busy must be ignored
        v = vecs[0];
        v.c_addr = 16'h0D00;
        expect_vec(v);
        d0 = done_cnt;
        launch(v, n);
        repeat (3) tick();
        a_base = 16'h0900; b_base = 16'h0A00; len = 8'd1; c_addr = 16'h0E00;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_done(v, n);
        repeat (20) tick();
        chk("single_done_pulse", 32'(done_cnt - d0), 32'd1);

        chk("strobe_exclusive", 32'(excl_err), 32'd0);
        chk("idle_outputs_zero", 32'(idle_err), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
